vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_if.sv | 46 ++++
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 tb/tb_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - pixel, CPU and VRAM signal bundle around the VRAM arbiter
interface vram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    // Video timing side
    logic          frame_start;
    logic          pix_pop;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          underflow;

    // CPU side
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    // VRAM side
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // The arbiter serves pixel and CPU requests and owns the VRAM bus
    modport slave (
        input  frame_start, pix_pop,
        output pix_data, pix_valid, underflow,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    // The surrounding system: timing generator, CPU port and the RAM itself
    modport master (
        output frame_start, pix_pop,
        input  pix_data, pix_valid, underflow,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM shared between scanout prefetch FIFO and CPU port
module vram_arbiter #(
    parameter int AW          = 14,
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_WORDS = 16384
) (
    input  logic            pclk,
    input  logic            reset,
    vram_arbiter_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int NW = CW + 1;
    localparam logic [NW-1:0] OCC_HALF  = NW'(FIFO_DEPTH / 2);
    localparam logic [NW-1:0] OCC_FULL  = NW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(FRAME_WORDS - 1);

    // Prefetch FIFO storage and bookkeeping
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [CW-1:0] rd_ptr_q, wr_ptr_q;
    logic [NW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic          fifo_push, fifo_pop, fifo_empty;
    logic [DW-1:0] head_hold_q;
    logic          underflow_q;

    // Scanout and access tracking
    logic [AW-1:0] scan_addr_q, scan_addr_d;
    logic          vid_inflight_q;
    logic          cpu_inflight_q;
    logic          cpu_rd_inflight_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [NW-1:0] occ;

    // RAM bus: the last issued address/data are held while idle
    logic [AW-1:0] ram_addr_q, ram_addr_c;
    logic [DW-1:0] ram_wdata_q, ram_wdata_c;
    logic          ram_we_c;

    logic          cpu_ok, vid_issue, cpu_issue;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign occ        = fifo_cnt_q + NW'(vid_inflight_q);
    // The cycle holding cpu_ack is the cycle with the CPU access in flight,
    // so this also keeps a still-held request from being served twice.
    assign cpu_ok     = bus.cpu_req && !cpu_inflight_q;

    // A word returning during frame_start belongs to the old frame and is dropped
    assign fifo_push  = vid_inflight_q && !bus.frame_start;
    assign fifo_pop   = bus.pix_pop && !fifo_empty && !bus.frame_start;

    // Slot arbitration: urgent scanout, then CPU, then opportunistic scanout
    always_comb begin
        vid_issue = 1'b0;
        cpu_issue = 1'b0;
        if (!reset) begin
            if (bus.frame_start) begin
                cpu_issue = cpu_ok;
            end else if (occ < OCC_HALF) begin
                vid_issue = 1'b1;
            end else if (cpu_ok) begin
                cpu_issue = 1'b1;
            end else if (occ < OCC_FULL) begin
                vid_issue = 1'b1;
            end
        end
    end

    // Drive the VRAM bus for the access chosen this cycle
    always_comb begin
        ram_addr_c  = ram_addr_q;
        ram_we_c    = 1'b0;
        ram_wdata_c = ram_wdata_q;
        if (cpu_issue) begin
            ram_addr_c = bus.cpu_addr;
            ram_we_c   = bus.cpu_we;
            if (bus.cpu_we) begin
                ram_wdata_c = bus.cpu_wdata;
            end
        end else if (vid_issue) begin
            ram_addr_c = scan_addr_q;
        end
    end

    // Next scanout address and FIFO count
    always_comb begin
        scan_addr_d = scan_addr_q;
        fifo_cnt_d  = fifo_cnt_q + NW'(fifo_push) - NW'(fifo_pop);
        if (bus.frame_start) begin
            scan_addr_d = '0;
            fifo_cnt_d  = '0;
        end else if (vid_issue) begin
            scan_addr_d = (scan_addr_q == LAST_WORD) ? '0 : scan_addr_q + AW'(1);
        end
    end

    // Control state, pointers and held outputs
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            scan_addr_q       <= '0;
            fifo_cnt_q        <= '0;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            vid_inflight_q    <= 1'b0;
            cpu_inflight_q    <= 1'b0;
            cpu_rd_inflight_q <= 1'b0;
            cpu_rdata_q       <= '0;
            head_hold_q       <= '0;
            underflow_q       <= 1'b0;
            ram_addr_q        <= '0;
            ram_wdata_q       <= '0;
        end else begin
            scan_addr_q       <= scan_addr_d;
            fifo_cnt_q        <= fifo_cnt_d;
            vid_inflight_q    <= vid_issue;
            cpu_inflight_q    <= cpu_issue;
            cpu_rd_inflight_q <= cpu_issue && !bus.cpu_we;
            ram_addr_q        <= ram_addr_c;
            ram_wdata_q       <= ram_wdata_c;
            if (cpu_rd_inflight_q) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
            if (!fifo_empty) begin
                head_hold_q <= fifo_mem[rd_ptr_q];
            end
            if (bus.pix_pop && fifo_empty) begin
                underflow_q <= 1'b1;
            end
            if (bus.frame_start) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (fifo_push) begin
                    wr_ptr_q <= wr_ptr_q + CW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr_q <= rd_ptr_q + CW'(1);
                end
            end
        end
    end

    // FIFO storage needs no reset: entries are only read after being written
    always_ff @(posedge pclk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= bus.ram_rdata;
        end
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.cpu_ack   = cpu_inflight_q;
    assign bus.cpu_rdata = cpu_rd_inflight_q ? bus.ram_rdata : cpu_rdata_q;
    assign bus.pix_valid = !fifo_empty;
    assign bus.pix_data  = fifo_empty ? head_hold_q : fifo_mem[rd_ptr_q];
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter
module tb_vram_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME_WORDS = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } cpu_txn_t;

    logic pclk;
    logic reset;
    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .pclk (pclk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] vram [2**AW];
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] exp_pix [$];
    cpu_txn_t      cpu_exp [$];

    int n_checks = 0;
    int n_fail   = 0;
    logic          uf_model = 1'b0;
    logic          acked = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_we;
    logic [DW-1:0] prev_wdata;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Synchronous write-first VRAM model
    always @(posedge pclk) begin
        if (bus.ram_we) begin
            vram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= bus.ram_wdata;
        end else begin
            bus.ram_rdata <= vram[bus.ram_addr];
        end
    end

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 7 + 3) & 255);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic refill_pix();
        exp_pix.delete();
        for (int k = 0; k < 200; k++) exp_pix.push_back(pat(k % FRAME_WORDS));
    endtask

    // Negedge sampling: pixel and CPU scoreboards, sticky underflow, FIFO overflow guard
    task automatic sample();
        cpu_txn_t e;
        @(negedge pclk);
        check_eq("underflow", bus.underflow, uf_model);
        check_eq("no_push_when_full", dut.fifo_push && (dut.fifo_cnt_q == FIFO_DEPTH), 1'b0);
        if (bus.pix_pop && !bus.frame_start) begin
            if (bus.pix_valid) begin
                check_eq("pix_exp_avail", exp_pix.size() != 0, 1'b1);
                if (exp_pix.size() != 0) check_eq("pix_data", bus.pix_data, exp_pix.pop_front());
            end else begin
                uf_model = 1'b1;
            end
        end
        if (bus.cpu_ack) begin
            check_eq("cpu_ack_expected", cpu_exp.size() != 0, 1'b1);
            if (cpu_exp.size() != 0) begin
                e = cpu_exp.pop_front();
                check_eq("cpu_ram_addr", prev_addr, e.addr);
                check_eq("cpu_ram_we", prev_we, e.we);
                if (e.we) check_eq("cpu_ram_wdata", prev_wdata, e.wdata);
                else      check_eq("cpu_rdata", bus.cpu_rdata, e.rdata);
            end
            acked = 1'b1;
        end
        prev_addr  = bus.ram_addr;
        prev_we    = bus.ram_we;
        prev_wdata = bus.ram_wdata;
        if (bus.frame_start) refill_pix();
    endtask

    task automatic advance();
        @(posedge pclk);
        #1;
        if (acked) begin
            bus.cpu_req = 1'b0;
            acked = 1'b0;
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic start_cpu(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cpu_txn_t e;
        e.addr = addr;
        e.we = we;
        e.wdata = wd;
        e.rdata = shadow.exists(int'(addr)) ? shadow[int'(addr)] : pat(int'(addr));
        if (we) shadow[int'(addr)] = wd;
        cpu_exp.push_back(e);
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wd;
        bus.cpu_req = 1'b1;
    endtask

    task automatic wait_cpu(input int bound, output int n);
        n = 0;
        while (bus.cpu_req && n < bound) begin
            tick();
            n++;
        end
        check_eq("cpu_ack_within_bound", bus.cpu_req, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pix_data"}, bus.pix_data, 0);
        check_eq({tag, "_pix_valid"}, bus.pix_valid, 0);
        check_eq({tag, "_underflow"}, bus.underflow, 0);
        check_eq({tag, "_cpu_ack"}, bus.cpu_ack, 0);
        check_eq({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        check_eq({tag, "_ram_addr"}, bus.ram_addr, 0);
        check_eq({tag, "_ram_we"}, bus.ram_we, 0);
        check_eq({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int a = 0; a < 2**AW; a++) vram[a] = pat(a);
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_pop = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        refill_pix();

        // Fill after reset: eight reads at 0..7, then idle with address held
        for (int c = 0; c < 11; c++) begin
            sample();
            check_eq("t1_ram_addr", bus.ram_addr, (c < 8) ? c : 7);
            check_eq("t1_ram_we", bus.ram_we, 0);
            check_eq("t1_pix_valid", bus.pix_valid, c >= 2);
            if (c >= 2) check_eq("t1_head", bus.pix_data, exp_pix[0]);
            advance();
        end

        // CPU write then read back with FIFO full
        start_cpu(1'b1, 14'h0100, 8'hA5);
        wait_cpu(8, n);
        check_eq("t2_write_latency", n, 2);
        start_cpu(1'b0, 14'h0100, 8'h00);
        wait_cpu(8, n);
        check_eq("t2_read_latency", n, 2);

        // Drain to five with a read in flight, then restart the frame
        bus.pix_pop = 1'b1;
        repeat (3) tick();
        start_cpu(1'b1, 14'h0200, 8'h3C);
        repeat (2) tick();
        check_eq("t4_cpu_done", bus.cpu_req, 0);
        bus.frame_start = 1'b1;
        sample();
        check_eq("t4_valid_at_restart", bus.pix_valid, 1);
        advance();
        bus.frame_start = 1'b0;
        bus.pix_pop = 1'b0;
        sample();
        check_eq("t4_fifo_cleared", bus.pix_valid, 0);
        check_eq("t4_restart_addr", bus.ram_addr, 0);
        check_eq("t4_restart_we", bus.ram_we, 0);
        advance();
        sample();
        check_eq("t4_inflight_discarded", bus.pix_valid, 0);
        advance();
        sample();
        check_eq("t4_first_valid", bus.pix_valid, 1);
        check_eq("t4_first_word", bus.pix_data, exp_pix[0]);
        advance();
        repeat (10) tick();

        // Pops every cycle starve the CPU; it is served soon after pops stop
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        start_cpu(1'b0, 14'h0100, 8'h00);
        repeat (2) tick();
        bus.pix_pop = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            check_eq("t3_cpu_held_off", bus.cpu_ack, 0);
            advance();
        end
        bus.pix_pop = 1'b0;
        wait_cpu(8, n);
        check_eq("t3_grant_after_pops", n <= 4, 1);

        // Long pop run across several 15 -> 0 scanout wraps
        repeat (10) tick();
        bus.pix_pop = 1'b1;
        repeat (40) tick();
        bus.pix_pop = 1'b0;
        tick();

        // Underflow right after reset is sticky until the next reset
        reset = 1'b1;
        #1;
        check_reset_outputs("reset2");
        uf_model = 1'b0;
        cpu_exp.delete();
        acked = 1'b0;
        @(posedge pclk);
        #1;
        reset = 1'b0;
        refill_pix();
        bus.pix_pop = 1'b1;
        tick();
        bus.pix_pop = 1'b0;
        sample();
        check_eq("t6_underflow_set", bus.underflow, 1);
        check_eq("t6_pix_data", bus.pix_data, 0);
        advance();
        repeat (12) tick();
        check_eq("t6_underflow_sticky", bus.underflow, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_cleared_by_reset", bus.underflow, 0);
        uf_model = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
